// File: rtl/nic_pkg.sv
// Shared constants for the NIC: register map and packet header field positions.
package nic_pkg;

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    localparam int unsigned PKT_VC          = 63;
    localparam int unsigned PKT_DIR_MSB     = 62;
    localparam int unsigned PKT_DIR_LSB     = 61;
    localparam int unsigned PKT_HOP_MSB     = 55;
    localparam int unsigned PKT_HOP_LSB     = 48;
    localparam int unsigned PKT_SRC_MSB     = 47;
    localparam int unsigned PKT_SRC_LSB     = 32;
    localparam int unsigned PKT_PAYLOAD_MSB = 31;
    localparam int unsigned PKT_PAYLOAD_LSB = 0;

endpackage

// File: rtl/nic_channel_buffer.sv
// One-entry packet buffer with a full flag; loads are refused while full.
module nic_channel_buffer
    import nic_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             unload,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            data <= '0;
            full <= 1'b0;
        end else if (load && !full) begin
            data <= load_data;
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/nic.sv
// Network interface controller: memory-mapped processor port bridged to a
// router PE port through one injection and one ejection buffer.
module nic
    import nic_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = 63
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    logic                  in_full;
    logic                  out_full;
    logic [DATA_WIDTH-1:0] in_buf;
    logic [DATA_WIDTH-1:0] out_buf;
    logic                  rd;
    logic                  wr_out;
    logic                  rd_in;

    assign rd     = nicEn & ~nicWrEn;
    assign wr_out = nicEn & nicWrEn & (addr == ADDR_OUT_BUF);
    assign rd_in  = rd & (addr == ADDR_IN_BUF);

    // Inject only in the router's phase matching the packet's virtual channel.
    assign net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity);
    assign net_do = out_buf;
    assign net_ri = ~in_full;

    nic_channel_buffer #(.WIDTH(DATA_WIDTH)) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (wr_out),
        .load_data (d_in),
        .unload    (net_so),
        .data      (out_buf),
        .full      (out_full)
    );

    nic_channel_buffer #(.WIDTH(DATA_WIDTH)) u_in_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (net_si),
        .load_data (net_di),
        .unload    (rd_in),
        .data      (in_buf),
        .full      (in_full)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            d_out <= '0;
        end else if (rd) begin
            case (addr)
                ADDR_IN_BUF:   d_out <= in_buf;
                ADDR_IN_STAT:  d_out <= {{(DATA_WIDTH-1){1'b0}}, in_full};
                ADDR_OUT_BUF:  d_out <= out_buf;
                ADDR_OUT_STAT: d_out <= {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:       d_out <= '0;
            endcase
        end else begin
            d_out <= '0;
        end
    end

endmodule

// File: tb/tb_nic.sv
// Self-checking bench for nic: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    int errors = 0;
    int checks = 0;
    int so_cnt = 0;

    always #5 clk = ~clk;

    nic #(.DATA_WIDTH(64), .VC_BIT(63)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each direction is a queue holding at most one packet.
    logic [63:0] in_q[$];
    logic [63:0] out_q[$];
    logic [63:0] in_last  = '0;
    logic [63:0] out_last = '0;
    logic [63:0] exp_dout = '0;

    initial begin
        bit sent, got, rd, wr_ok, clr;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                in_q.delete();
                out_q.delete();
                in_last  = '0;
                out_last = '0;
                exp_dout = '0;
            end else begin
                sent  = (out_q.size() != 0) && net_ro && (out_q[0][63] == net_polarity);
                got   = net_si && (in_q.size() == 0);
                rd    = nicEn && !nicWrEn;
                wr_ok = nicEn && nicWrEn && (addr == 2'b10) && (out_q.size() == 0);
                clr   = rd && (addr == 2'b00) && (in_q.size() != 0);
                if (!rd)                exp_dout = '0;
                else if (addr == 2'b00) exp_dout = in_last;
                else if (addr == 2'b01) exp_dout = 64'(in_q.size());
                else if (addr == 2'b10) exp_dout = out_last;
                else                    exp_dout = 64'(out_q.size());
                if (clr)  void'(in_q.pop_front());
                if (got)  begin in_q.push_back(net_di); in_last = net_di; end
                if (sent) void'(out_q.pop_front());
                if (wr_ok) begin out_q.push_back(d_in); out_last = d_in; end
            end
            chk("model_d_out",  d_out,  exp_dout);
            chk("model_net_ri", 64'(net_ri), 64'(in_q.size() == 0));
            chk("model_net_do", net_do, out_last);
            chk("model_net_so", 64'(net_so),
                64'((out_q.size() != 0) && net_ro && (out_q[0][63] == net_polarity)));
        end
    end

    // Count injections at a point where both state and inputs are settled.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (net_so === 1'b1) so_cnt++;
        end
    end

    task automatic idle();
        nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = '0; net_si = 1'b0;
    endtask

    task automatic drive(input logic en, input logic wr, input logic [1:0] a, input logic [63:0] d);
        nicEn = en; nicWrEn = wr; addr = a; d_in = d;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int c0;
        reset = 1'b0; net_ro = 1'b0; net_polarity = 1'b0; net_di = '0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        #1;
        chk("rst_d_out",  d_out,  64'h0);
        chk("rst_net_so", 64'(net_so), 64'h0);
        chk("rst_net_ri", 64'(net_ri), 64'h1);
        chk("rst_net_do", net_do, 64'h0);
        drive(1, 0, 2'b11, '0); after_edge(); chk("rst_out_stat", d_out, 64'h0);
        @(negedge clk); drive(1, 0, 2'b01, '0); after_edge(); chk("rst_in_stat", d_out, 64'h0);

        // Injection with matching polarity
        @(negedge clk); net_ro = 1'b1; net_polarity = 1'b1; c0 = so_cnt;
        drive(1, 1, 2'b10, 64'h8010_0000_1111_1111);
        after_edge();
        chk("inj_net_so", 64'(net_so), 64'h1);
        chk("inj_net_do", net_do, 64'h8010_0000_1111_1111);
        @(negedge clk); idle();
        @(negedge clk); drive(1, 0, 2'b11, '0); after_edge();
        chk("inj_out_stat", d_out, 64'h0);
        chk("inj_sent_once", 64'(so_cnt - c0), 64'h1);

        // Polarity gating
        @(negedge clk); net_ro = 1'b0; drive(1, 1, 2'b10, 64'h8010_0000_1111_1111);
        @(posedge clk);
        c0 = so_cnt;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle(); net_ro = 1'b1; net_polarity = i[0];
            #1;
            chk("pol_net_so", 64'(net_so), (i == 1) ? 64'h1 : 64'h0);
        end
        @(posedge clk); #2;
        chk("pol_sent_once", 64'(so_cnt - c0), 64'h1);

        // Backpressure and write-while-full
        @(negedge clk); net_ro = 1'b0; drive(1, 1, 2'b10, 64'hA);
        @(negedge clk); drive(1, 1, 2'b10, 64'hB);
        @(negedge clk); drive(1, 0, 2'b11, '0); after_edge();
        chk("bp_out_stat", d_out, 64'h1);
        chk("bp_net_do", net_do, 64'hA);
        @(negedge clk); idle(); net_ro = 1'b1; net_polarity = 1'b0; c0 = so_cnt;
        repeat (3) @(posedge clk);
        #2;
        chk("bp_sent_once", 64'(so_cnt - c0), 64'h1);
        chk("bp_net_do_kept", net_do, 64'hA);

        // Ejection
        @(negedge clk); net_si = 1'b1; net_di = 64'h0000_0000_DEAD_BEEF;
        after_edge();
        chk("ej_net_ri", 64'(net_ri), 64'h0);
        @(negedge clk); net_si = 1'b0; drive(1, 0, 2'b01, '0); after_edge();
        chk("ej_in_stat", d_out, 64'h1);
        @(negedge clk); drive(1, 0, 2'b00, '0); after_edge();
        chk("ej_d_out", d_out, 64'h0000_0000_DEAD_BEEF);
        chk("ej_net_ri_after", 64'(net_ri), 64'h1);

        // Reset mid-operation with both buffers full
        @(negedge clk); net_ro = 1'b0; drive(1, 1, 2'b10, 64'h8000_0000_0000_0077);
        net_si = 1'b1; net_di = 64'h1234;
        @(negedge clk); idle(); reset = 1'b0;
        @(negedge clk); reset = 1'b1; net_ro = 1'b1; net_polarity = 1'b1;
        #1;
        chk("mid_rst_net_so", 64'(net_so), 64'h0);
        chk("mid_rst_net_ri", 64'(net_ri), 64'h1);
        @(negedge clk); drive(1, 0, 2'b11, '0); after_edge(); chk("mid_rst_out_stat", d_out, 64'h0);
        @(negedge clk); drive(1, 0, 2'b01, '0); after_edge(); chk("mid_rst_in_stat", d_out, 64'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset        = ($urandom_range(0, 99) != 0);
            nicEn        = ($urandom_range(0, 3) != 0);
            nicWrEn      = $urandom_range(0, 1) != 0;
            addr         = 2'($urandom_range(0, 3));
            d_in         = {$urandom, $urandom};
            net_si       = ($urandom_range(0, 2) == 0);
            net_di       = {$urandom, $urandom};
            net_ro       = ($urandom_range(0, 9) < 7);
            net_polarity = $urandom_range(0, 1) != 0;
        end
        @(negedge clk); idle(); reset = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nic.md
Name: nic

Overview:
- Network interface controller placed between a processing element and the PE port (pesi/pedi/peri, peso/pero/pedo) of one mesh router.
- Exposes a 4-register, 64-bit memory-mapped interface to the processor.
  - One output channel buffer injects packets into the router.
  - One input channel buffer receives packets ejected by the router.
- Injection is gated by the router's even/odd `polarity` so packets enter only on their virtual-channel phase.

Parameters:
- DATA_WIDTH, 64, packet and processor data width.
- VC_BIT, 63, index of the virtual-channel bit in the packet header.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising edge of clk)
- addr  input  2  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status
- d_in  input  64  processor write data
- d_out  output  64  processor read data (registered)
- nicEn  input  1  processor access enable
- nicWrEn  input  1  1 = write, 0 = read (valid only with nicEn)
- net_si  input  1  router->NIC send (router peso)
- net_ri  output  1  NIC->router ready (router pero)
- net_di  input  64  router->NIC packet (router pedo)
- net_so  output  1  NIC->router send (router pesi)
- net_ro  input  1  router->NIC ready (router peri)
- net_do  output  64  NIC->router packet (router pedi)
- net_polarity  input  1  router polarity

Behaviour:
- Reset (reset==0 at an edge):
  - in_full=0, out_full=0, in_buf=0, out_buf=0, d_out=0.
  - Consequently net_so=0, net_ri=1, net_do=0.
  - Reset asserted mid-operation drops any buffered packet in either direction.
- Output channel (processor -> router):
  - Write accepted when nicEn & nicWrEn & addr==10 & ~out_full: out_buf<=d_in, out_full<=1 at the edge.
  - Write while out_full=1 is silently ignored; buffer contents are unchanged.
  - net_so = out_full & net_ro & (out_buf[VC_BIT]==net_polarity). This is combinational from registered state and inputs.
  - net_do = out_buf at all times.
  - When net_so=1 at an edge, out_full<=0. Earliest injection is the cycle after the write edge, so latency is 1 cycle.
  - Write and send in the same cycle cannot both occur, because the write requires pre-edge out_full=0.
- Input channel (router -> processor):
  - net_ri = ~in_full.
  - When net_si & ~in_full at an edge: in_buf<=net_di, in_full<=1.
  - net_si while in_full=1 is a protocol violation and is ignored; in_buf is not overwritten.
  - Read of addr 00 (nicEn & ~nicWrEn): d_out<=in_buf at the edge. If in_full=1, in_full<=0 at the same edge.
  - Reading addr 00 while empty returns stale in_buf and leaves state unchanged.
  - Arrival and clearing cannot coincide, because net_ri=0 while full.
- Status reads:
  - addr 01: d_out<={63'b0,in_full}.
  - addr 11: d_out<={63'b0,out_full}.
  - addr 10 read: d_out<=out_buf, with no side effect.
- d_out:
  - Updated only on a read access; read latency is 1 cycle.
  - When nicEn=0 or nicWrEn=1, d_out<=0.
- Writes to addr 00, 01 and 11 are ignored.
- Packet contents are never modified by the NIC.
  - Header layout, bits 63 down to 0: VC bit 63, direction bits 62:61, reserved bits 60:56, hop field bits 55:48, source bits 47:32, payload bits 31:0.

Decomposition:
- Shared package nic_pkg:
  - address constants ADDR_IN_BUF=2'b00, ADDR_IN_STAT=2'b01, ADDR_OUT_BUF=2'b10, ADDR_OUT_STAT=2'b11;
  - packet field index constants (VC, DIR, HOP, SRC, PAYLOAD msb/lsb).
- Sub-module nic_channel_buffer, instantiated twice (in and out):
  - one-entry register plus full flag;
  - ports load, load_data, unload, data, full.

Test Plan:
- Reset then idle:
  - Hold reset=0 for 2 cycles, release.
  - Expect d_out=0, net_so=0, net_ri=1, net_do=0.
  - Reading addr 11 and addr 01 returns 0.
- Injection with matching polarity:
  - Write addr 10 with d_in=64'h8010_0000_1111_1111 (VC=1); net_ro=1; net_polarity=1.
  - Expect net_so=1 and net_do=that value one cycle after the write.
  - Addr 11 reads 0 afterwards.
- Polarity gating:
  - Same packet with net_polarity toggling each cycle starting at 0.
  - Expect net_so=0 in the polarity=0 cycles and 1 in the first polarity=1 cycle; sent exactly once.
- Backpressure and write-while-full:
  - Set net_ro=0, write 64'hA, then write 64'hB.
  - Expect addr 11 reads 1 and net_do stays 64'hA.
  - Raise net_ro with matching polarity: 64'hA sent once; 64'hB never sent.
- Ejection:
  - Drive net_si=1, net_di=64'h0000_0000_DEAD_BEEF for one cycle.
  - Expect net_ri=0 next cycle and addr 01 reads 1.
  - Read addr 00 returns DEAD_BEEF on d_out one cycle later; net_ri=1 the cycle after the read.
- Reset mid-operation:
  - With both buffers full, assert reset=0 for one edge.
  - Expect net_so=0, net_ri=1, and both status registers read 0.
